// File: rtl/cell_display_pipe.sv
// Two-stage Life cell renderer with frame-synchronous double buffering.
// Optional grid-line overlay when GRID_LINES_EN is defined.
module cell_display_pipe #(
  parameter int          COLS       = 8,
  parameter int          ROWS       = 8,
  parameter int          CELL_LOG2  = 6,
  parameter logic [11:0] GRID_COLOR = 12'h333
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          x,
  input  logic [10:0]          y,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 blank_in,
  input  logic [COLS*ROWS-1:0] alive,
  input  logic [COLS*ROWS-1:0] alive_prev,
  input  logic                 gen_valid,
  input  logic                 color_enb,
  output logic [11:0]          rgb,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 blank_out,
  output logic                 frame_swap
);

  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] pend_a_q, pend_a_d;
  logic [N-1:0] pend_p_q, pend_p_d;
  logic [N-1:0] disp_a_q, disp_a_d;
  logic [N-1:0] disp_p_q, disp_p_d;
  logic         pend_flag_q, pend_flag_d;
  logic         frame_start;

  assign frame_start = (x == 11'd0) && (y == 11'd0) && !blank_in;
  assign frame_swap  = !reset && frame_start &&
                       (gen_valid || pend_flag_q);

  always_comb begin
    pend_a_d    = pend_a_q;
    pend_p_d    = pend_p_q;
    disp_a_d    = disp_a_q;
    disp_p_d    = disp_p_q;
    pend_flag_d = pend_flag_q;
    if (frame_start) begin
      // a generation arriving at frame start skips the pending stage
      if (gen_valid) begin
        disp_a_d = alive;
        disp_p_d = alive_prev;
      end else if (pend_flag_q) begin
        disp_a_d = pend_a_q;
        disp_p_d = pend_p_q;
      end
      pend_flag_d = 1'b0;
    end else if (gen_valid) begin
      pend_a_d    = alive;
      pend_p_d    = alive_prev;
      pend_flag_d = 1'b1;
    end
  end

  logic [10:0]   col, row;
  logic          in_rng_d, in_rng_q;
  logic [IW-1:0] idx_d, idx_q;
  logic          cenb_q;
  logic          hs1_q, vs1_q, bl1_q;
  logic [11:0]   rgb_d, rgb_q;
  logic          hs2_q, vs2_q, bl2_q;

  assign col      = x >> CELL_LOG2;
  assign row      = y >> CELL_LOG2;
  assign in_rng_d = (col < 11'(COLS)) && (row < 11'(ROWS));
  assign idx_d    = in_rng_d ?
                    IW'(32'(row) * COLS + 32'(col)) : '0;

`ifdef GRID_LINES_EN
  logic [CELL_LOG2-1:0] offx_q, offy_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_a_q    <= '0;
      pend_p_q    <= '0;
      disp_a_q    <= '0;
      disp_p_q    <= '0;
      pend_flag_q <= 1'b0;
      in_rng_q    <= 1'b0;
      idx_q       <= '0;
      cenb_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      bl1_q       <= 1'b1;
      rgb_q       <= '0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      bl2_q       <= 1'b1;
`ifdef GRID_LINES_EN
      offx_q      <= '0;
      offy_q      <= '0;
`endif
    end else begin
      pend_a_q    <= pend_a_d;
      pend_p_q    <= pend_p_d;
      disp_a_q    <= disp_a_d;
      disp_p_q    <= disp_p_d;
      pend_flag_q <= pend_flag_d;
      in_rng_q    <= in_rng_d;
      idx_q       <= idx_d;
      cenb_q      <= color_enb;
      hs1_q       <= hsync_in;
      vs1_q       <= vsync_in;
      bl1_q       <= blank_in;
      rgb_q       <= rgb_d;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      bl2_q       <= bl1_q;
`ifdef GRID_LINES_EN
      offx_q      <= x[CELL_LOG2-1:0];
      offy_q      <= y[CELL_LOG2-1:0];
`endif
    end
  end

  logic is_b, was_b;

  assign is_b  = disp_a_q[idx_q];
  assign was_b = disp_p_q[idx_q];

  always_comb begin
    rgb_d = 12'h000;
    if (!bl1_q && in_rng_q) begin
      if (cenb_q) begin
        unique case ({was_b, is_b})
          2'b00:   rgb_d = 12'h000;
          2'b10:   rgb_d = 12'hF00;
          2'b01:   rgb_d = 12'hFF0;
          default: rgb_d = 12'h0F0;
        endcase
      end else begin
        rgb_d = is_b ? 12'hFFF : 12'h000;
      end
`ifdef GRID_LINES_EN
      if (offx_q == '0 || offy_q == '0)
        rgb_d = GRID_COLOR;
`endif
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign blank_out = bl2_q;

endmodule

// File: tb/tb_cell_display_pipe.sv
// Scoreboard bench for cell_display_pipe: sparse frame sweeps
// against a behavioural display/pending model.
module tb_cell_display_pipe;

  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int CL   = 6;
  localparam int N    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y;
  logic          hsync_in, vsync_in, blank_in;
  logic [N-1:0]  alive, alive_prev;
  logic          gen_valid, color_enb;
  logic [11:0]   rgb;
  logic          hsync_out, vsync_out, blank_out, frame_swap;

  always #5 clk = ~clk;

  cell_display_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .blank_in   (blank_in),
    .alive      (alive),
    .alive_prev (alive_prev),
    .gen_valid  (gen_valid),
    .color_enb  (color_enb),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .blank_out  (blank_out),
    .frame_swap (frame_swap)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        bl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   in_vld = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;

  logic [N-1:0] m_da, m_dp, m_pa, m_pp;
  bit           m_pv;

  int xs[17] = '{0, 1, 63, 64, 65, 100, 127, 128, 300, 511,
                 512, 639, 640, 700, 1024, 1500, 2047};
  int ys[15] = '{0, 1, 63, 64, 70, 127, 128, 300, 447, 448,
                 479, 480, 520, 1024, 2047};

  localparam logic [N-1:0] ALL  = {N{1'b1}};
  localparam logic [N-1:0] NONE = '0;
  localparam logic [N-1:0] B9   = 64'h200;
  localparam logic [N-1:0] CHK  = 64'hAA55_AA55_AA55_AA55;
  localparam logic [N-1:0] B0   = 64'h1;

  function automatic logic [11:0] ref_rgb(int px, int py,
                                          bit bl, bit ce);
    int  c, r, i;
    bit  is_b, was_b;
    c = px >> CL;
    r = py >> CL;
    if (bl || c >= COLS || r >= ROWS) return 12'h000;
`ifdef GRID_LINES_EN
    if (px % 64 == 0 || py % 64 == 0) return 12'h333;
`endif
    i     = r * COLS + c;
    is_b  = m_da[i];
    was_b = m_dp[i];
    if (!ce) return is_b ? 12'hFFF : 12'h000;
    if (was_b && is_b) return 12'h0F0;
    if (was_b) return 12'hF00;
    if (is_b) return 12'hFF0;
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    v1 <= in_vld;
    v2 <= v1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (v2) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pipe_out: output with empty scoreboard");
      end else begin
        e = q.pop_front();
        if ({rgb, hsync_out, vsync_out, blank_out} !== e) begin
          bad++;
          $display("FAIL pipe_out: got rgb=%h hs=%b vs=%b bl=%b want rgb=%h hs=%b vs=%b bl=%b",
                   rgb, hsync_out, vsync_out, blank_out,
                   e.rgb, e.hs, e.vs, e.bl);
        end
      end
    end
  end

  task automatic step(input int px, input int py, input bit bl,
                      input bit gv, input logic [N-1:0] a,
                      input logic [N-1:0] p, input bit ce,
                      output bit fs_o, output bit fs_e);
    logic h, v;
    bit   fst;
    h = 1'($urandom_range(0, 1));
    v = 1'($urandom_range(0, 1));
    x          = 11'(px);
    y          = 11'(py);
    blank_in   = bl;
    hsync_in   = h;
    vsync_in   = v;
    gen_valid  = gv;
    color_enb  = ce;
    alive      = gv ? a : {$urandom, $urandom};
    alive_prev = gv ? p : {$urandom, $urandom};
    fst  = (px == 0) && (py == 0) && !bl;
    fs_e = fst && (gv || m_pv);
    if (fst) begin
      if (gv) begin
        m_da = a;
        m_dp = p;
      end else if (m_pv) begin
        m_da = m_pa;
        m_dp = m_pp;
      end
      m_pv = 1'b0;
    end else if (gv) begin
      m_pa = a;
      m_pp = p;
      m_pv = 1'b1;
    end
    q.push_back('{ref_rgb(px, py, bl, ce), h, v, bl});
    in_vld = 1'b1;
    #1;
    fs_o = frame_swap;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input bit ce, input bit wide,
                       input int g1, input logic [N-1:0] a1,
                       input logic [N-1:0] p1,
                       input int g2, input logic [N-1:0] a2,
                       input logic [N-1:0] p2);
    int idx = 0;
    bit bl, gv, fo, fe;
    for (int yi = 0; yi < 15; yi++) begin
      for (int xi = 0; xi < 17; xi++) begin
        bl = (ys[yi] >= 480) || (!wide && xs[xi] >= 640);
        gv = (idx == g1) || (idx == g2);
        step(xs[xi], ys[yi], bl, gv,
             (idx == g2) ? a2 : a1, (idx == g2) ? p2 : p1,
             ce, fo, fe);
        total++;
        if (fo !== fe) begin
          bad++;
          $display("FAIL frame_swap at x=%0d y=%0d: got %b want %b",
                   xs[xi], ys[yi], fo, fe);
        end
        idx++;
      end
    end
  endtask

  task automatic drain();
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drain();
    x = 11'd0; y = 11'd0; blank_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    gen_valid = 1'b1; color_enb = 1'b1;
    alive = ALL; alive_prev = ALL;
    reset = 1'b1;
    #1;
    total++;
    if (frame_swap !== 1'b0) begin
      bad++;
      $display("FAIL reset_swap: got %b want 0", frame_swap);
    end
    @(posedge clk);
    #1;
    total++;
    if ({rgb, hsync_out, vsync_out, blank_out} !== {12'h000, 3'b001}) begin
      bad++;
      $display("FAIL reset_out: got rgb=%h hs=%b vs=%b bl=%b want 000 0 0 1",
               rgb, hsync_out, vsync_out, blank_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    gen_valid = 1'b0;
    m_da = '0; m_dp = '0; m_pa = '0; m_pp = '0; m_pv = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_idle_frame();
    sweep(1'b0, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
    sweep(1'b1, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
  endtask

  task automatic test_single_cell();
    bit fo, fe;
    step(700, 500, 1'b1, 1'b1, B9, NONE, 1'b0, fo, fe);
    total++;
    if (fo !== 1'b0) begin
      bad++;
      $display("FAIL capture_swap: got %b want 0", fo);
    end
    sweep(1'b0, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
    sweep(1'b1, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
  endtask

  task automatic test_mid_frame();
    sweep(1'b1, 1'b0, 100, ALL, NONE, -1, NONE, NONE);
    sweep(1'b1, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
    sweep(1'b0, 1'b0, 30, B0, NONE, 150, CHK, NONE);
    sweep(1'b0, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
  endtask

  task automatic test_start_bypass();
    bit fo, fe;
    step(800, 10, 1'b1, 1'b1, B0, B0, 1'b1, fo, fe);
    sweep(1'b1, 1'b0, 0, CHK, ~CHK, -1, NONE, NONE);
    sweep(1'b1, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
  endtask

  task automatic test_out_of_range();
    sweep(1'b1, 1'b1, 0, ALL, ALL, -1, NONE, NONE);
    sweep(1'b1, 1'b1, 0, NONE, ALL, -1, NONE, NONE);
    sweep(1'b0, 1'b1, 0, ALL, NONE, -1, NONE, NONE);
  endtask

  task automatic test_reset_mid();
    bit fo, fe;
    sweep(1'b0, 1'b0, 0, ALL, NONE, -1, NONE, NONE);
    drain();
    x = 11'd65; y = 11'd65; blank_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; color_enb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rgb !== 12'hFFF) begin
      bad++;
      $display("FAIL pre_reset_pixel: got %h want fff", rgb);
    end
    apply_reset();
    sweep(1'b0, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
    step(900, 600, 1'b1, 1'b1, CHK, NONE, 1'b0, fo, fe);
    sweep(1'b0, 1'b0, -1, NONE, NONE, -1, NONE, NONE);
  endtask

  initial begin
    reset = 1'b0;
    x = '0; y = '0; blank_in = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0;
    alive = '0; alive_prev = '0;
    gen_valid = 1'b0; color_enb = 1'b0;
    m_da = '0; m_dp = '0; m_pa = '0; m_pp = '0; m_pv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_idle_frame();
    test_single_cell();
    test_mid_frame();
    test_start_bypass();
    test_out_of_range();
    test_reset_mid();
    drain();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
